// File: rtl/count_sequencer_if.sv
// Request handshake and counter-control bus for count_sequencer.
// The master side issues requests and hosts the counter; the slave side is the sequencer.
interface count_sequencer_if #(
   parameter int PRESCALE_W = 4
);
   logic                  req_valid;
   logic                  req_ready;
   logic [7:0]            req_count;
   logic [PRESCALE_W-1:0] req_div;
   logic                  req_repeat;
   logic [7:0]            cnt_in;
   logic                  cnt_latch;
   logic                  cnt_dec;
   logic                  zero;

   modport master (
      output req_valid, req_count, req_div, req_repeat, zero,
      input  req_ready, cnt_in, cnt_latch, cnt_dec
   );

   modport slave (
      input  req_valid, req_count, req_div, req_repeat, zero,
      output req_ready, cnt_in, cnt_latch, cnt_dec
   );
endinterface

// File: rtl/count_sequencer.sv
// Sequencer for an 8-bit down counter: loads it, issues prescaled decrements,
// and pulses done when the counter reaches zero, optionally reloading for periodic operation.
module count_sequencer #(
   parameter int PRESCALE_W = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   count_sequencer_if.slave   bus,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic [7:0]         periods
);
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t                r_state;
   logic [7:0]            r_cnt_in;
   logic [PRESCALE_W-1:0] r_div;
   logic [PRESCALE_W-1:0] r_pre;
   logic                  r_rep;
   logic [7:0]            r_periods;

   logic w_ready;
   logic w_accept;
   logic w_pre_hit;

   assign w_ready   = (r_state == S_IDLE) && !abort;
   assign w_accept  = bus.req_valid && w_ready;
   assign w_pre_hit = (r_pre == r_div);

   // Strobes are gated by abort so a cancelled cycle never touches the counter.
   assign bus.req_ready = w_ready;
   assign bus.cnt_latch = (r_state == S_LOAD) && !abort;
   assign bus.cnt_dec   = (r_state == S_RUN) && w_pre_hit && !bus.zero && !abort;
   assign bus.cnt_in    = r_cnt_in;
   assign done          = (r_state == S_DONE) && !abort;
   assign busy          = (r_state != S_IDLE);
   assign periods       = r_periods;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_cnt_in  <= 8'd0;
         r_div     <= '0;
         r_pre     <= '0;
         r_rep     <= 1'b0;
         r_periods <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt_in  <= bus.req_count;
                  r_div     <= bus.req_div;
                  r_rep     <= bus.req_repeat;
                  r_periods <= 8'd0;
                  r_pre     <= '0;
                  r_state   <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (abort) begin
                  r_state <= S_IDLE;
               end else begin
                  r_pre   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (abort) begin
                  r_state <= S_IDLE;
               end else begin
                  r_pre <= w_pre_hit ? '0 : r_pre + PRESCALE_W'(1);
                  if (bus.zero) begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (abort) begin
                  r_state <= S_IDLE;
               end else begin
                  // Period count saturates rather than wrapping.
                  if (r_periods != 8'hFF) begin
                     r_periods <= r_periods + 8'd1;
                  end
                  r_state <= r_rep ? S_LOAD : S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_count_sequencer.sv
// Directed testbench for count_sequencer with a behavioural down-counter model driving zero.
module tb_count_sequencer;
   logic       clock = 1'b0;
   logic       reset_n;
   logic       abort;
   logic       busy;
   logic       done;
   logic [7:0] periods;

   int checks = 0;
   int errors = 0;

   logic [63:0] lg_latch, lg_dec, lg_done, lg_busy, lg_ready;
   logic [7:0]  lg_per [64];
   logic [7:0]  ctr = 8'd0;

   count_sequencer_if #(.PRESCALE_W(4)) bus ();

   count_sequencer #(.PRESCALE_W(4)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus),
      .abort   (abort),
      .busy    (busy),
      .done    (done),
      .periods (periods)
   );

   always #5 clock = ~clock;

   // Down counter being controlled.
   always @(posedge clock) begin
      if (bus.cnt_latch) ctr <= bus.cnt_in;
      else if (bus.cnt_dec) ctr <= ctr - 8'd1;
   end
   assign bus.zero = (ctr == 8'd0);

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present a request at window cycle 0 and log outputs for ncyc cycles.
   task automatic do_req(input logic [7:0] n, input logic [3:0] d, input logic rep, input int ncyc);
      lg_latch = '0; lg_dec = '0; lg_done = '0; lg_busy = '0; lg_ready = '0;
      bus.req_valid = 1'b1; bus.req_count = n; bus.req_div = d; bus.req_repeat = rep;
      for (int c = 0; c < ncyc; c++) begin
         lg_latch[c] = bus.cnt_latch; lg_dec[c] = bus.cnt_dec; lg_done[c] = done;
         lg_busy[c] = busy; lg_ready[c] = bus.req_ready; lg_per[c] = periods;
         tick();
         bus.req_valid = 1'b0;
      end
      $display("req N=%0d D=%0d rep=%0d: latch=%h dec=%h done=%h busy=%h ready=%h",
               n, d, rep, lg_latch, lg_dec, lg_done, lg_busy, lg_ready);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; abort = 1'b0;
      bus.req_valid = 1'b0; bus.req_count = 8'd0; bus.req_div = 4'd0; bus.req_repeat = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checks++; if ({bus.cnt_latch, bus.cnt_dec, done, busy} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {bus.cnt_latch, bus.cnt_dec, done, busy}); end
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready); end
      checks++; if ({bus.cnt_in, periods} !== 16'h0000) begin errors++; $display("FAIL reset_regs: got %h expected 0000", {bus.cnt_in, periods}); end
      abort = 1'b1; #1;
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_abort: got %b expected 0", bus.req_ready); end
      abort = 1'b0; reset_n = 1'b1;
      tick();
      $display("reset done");
   endtask

   task automatic test_basic();
      do_req(8'd3, 4'd0, 1'b0, 10);
      checks++; if (lg_latch !== 64'h2) begin errors++; $display("FAIL basic_latch: got %h expected %h", lg_latch, 64'h2); end
      checks++; if (lg_dec !== 64'h1C) begin errors++; $display("FAIL basic_dec: got %h expected %h", lg_dec, 64'h1C); end
      checks++; if (lg_done !== 64'h40) begin errors++; $display("FAIL basic_done: got %h expected %h", lg_done, 64'h40); end
      checks++; if (lg_busy !== 64'h7E) begin errors++; $display("FAIL basic_busy: got %h expected %h", lg_busy, 64'h7E); end
      checks++; if (lg_ready !== 64'h381) begin errors++; $display("FAIL basic_ready: got %h expected %h", lg_ready, 64'h381); end
      checks++; if (periods !== 8'd1) begin errors++; $display("FAIL basic_periods: got %0d expected 1", periods); end
      checks++; if (bus.cnt_in !== 8'd3) begin errors++; $display("FAIL basic_cnt_in: got %0d expected 3", bus.cnt_in); end
   endtask

   task automatic test_prescale();
      do_req(8'd2, 4'd2, 1'b0, 12);
      checks++; if (lg_latch !== 64'h2) begin errors++; $display("FAIL pre_latch: got %h expected %h", lg_latch, 64'h2); end
      checks++; if (lg_dec !== 64'h90) begin errors++; $display("FAIL pre_dec: got %h expected %h", lg_dec, 64'h90); end
      checks++; if (lg_done !== 64'h200) begin errors++; $display("FAIL pre_done: got %h expected %h", lg_done, 64'h200); end
      checks++; if (lg_busy !== 64'h3FE) begin errors++; $display("FAIL pre_busy: got %h expected %h", lg_busy, 64'h3FE); end
   endtask

   task automatic test_zero_count();
      do_req(8'd0, 4'd5, 1'b0, 6);
      checks++; if (lg_latch !== 64'h2) begin errors++; $display("FAIL n0_latch: got %h expected %h", lg_latch, 64'h2); end
      checks++; if (lg_dec !== 64'h0) begin errors++; $display("FAIL n0_dec: got %h expected %h", lg_dec, 64'h0); end
      checks++; if (lg_done !== 64'h8) begin errors++; $display("FAIL n0_done: got %h expected %h", lg_done, 64'h8); end
      checks++; if (lg_busy !== 64'hE) begin errors++; $display("FAIL n0_busy: got %h expected %h", lg_busy, 64'hE); end
   endtask

   task automatic test_repeat();
      do_req(8'd1, 4'd0, 1'b1, 14);
      checks++; if (lg_done !== 64'h1110) begin errors++; $display("FAIL rep_done: got %h expected %h", lg_done, 64'h1110); end
      checks++; if (lg_latch !== 64'h2222) begin errors++; $display("FAIL rep_latch: got %h expected %h", lg_latch, 64'h2222); end
      checks++; if (lg_dec !== 64'h444) begin errors++; $display("FAIL rep_dec: got %h expected %h", lg_dec, 64'h444); end
      checks++; if (lg_ready !== 64'h1) begin errors++; $display("FAIL rep_ready: got %h expected %h", lg_ready, 64'h1); end
      checks++; if ({lg_per[5], lg_per[9], lg_per[13]} !== {8'd1, 8'd2, 8'd3}) begin errors++; $display("FAIL rep_periods: got %0d %0d %0d expected 1 2 3", lg_per[5], lg_per[9], lg_per[13]); end
      repeat (1200) tick();
      checks++; if (periods !== 8'd255) begin errors++; $display("FAIL rep_saturate: got %0d expected 255", periods); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rep_busy: got %b expected 1", busy); end
      $display("repeat: periods=%0d after long run", periods);
      abort = 1'b1; tick(); abort = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rep_abort_idle: got %b expected 0", busy); end
   endtask

   task automatic test_abort();
      bus.req_valid = 1'b1; bus.req_count = 8'd5; bus.req_div = 4'd0; bus.req_repeat = 1'b0;
      tick();                       // cycle 1: LOAD
      bus.req_valid = 1'b0;
      tick();                       // cycle 2: first dec
      checks++; if (bus.cnt_dec !== 1'b1) begin errors++; $display("FAIL abort_first_dec: got %b expected 1", bus.cnt_dec); end
      tick();                       // cycle 3: abort
      abort = 1'b1; #1;
      checks++; if ({bus.cnt_dec, done, bus.cnt_latch} !== 3'b000) begin errors++; $display("FAIL abort_strobes: got %b expected 000", {bus.cnt_dec, done, bus.cnt_latch}); end
      tick();
      abort = 1'b0; #1;
      checks++; if ({busy, done, bus.req_ready} !== 3'b001) begin errors++; $display("FAIL abort_idle: got %b expected 001", {busy, done, bus.req_ready}); end
      checks++; if (ctr !== 8'd4) begin errors++; $display("FAIL abort_ctr: got %0d expected 4", ctr); end
      abort = 1'b1; bus.req_valid = 1'b1; bus.req_count = 8'd2; #1;
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL abort_idle_ready: got %b expected 0", bus.req_ready); end
      tick();
      abort = 1'b0; bus.req_valid = 1'b0; #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle_accept: got %b expected 0", busy); end
      $display("abort: scenario complete");
      tick();
   endtask

   task automatic test_reset_mid();
      bus.req_valid = 1'b1; bus.req_count = 8'd4; bus.req_div = 4'd1; bus.req_repeat = 1'b0;
      tick();
      bus.req_valid = 1'b0;
      repeat (3) tick();            // cycle 4: RUN
      reset_n = 1'b0; #1;
      checks++; if ({bus.cnt_latch, bus.cnt_dec, done, busy, bus.req_ready} !== 5'b00001) begin errors++; $display("FAIL rst_mid_outputs: got %b expected 00001", {bus.cnt_latch, bus.cnt_dec, done, busy, bus.req_ready}); end
      checks++; if ({bus.cnt_in, periods} !== 16'h0000) begin errors++; $display("FAIL rst_mid_regs: got %h expected 0000", {bus.cnt_in, periods}); end
      tick();
      reset_n = 1'b1;
      tick();
      do_req(8'd2, 4'd1, 1'b0, 10);
      checks++; if (lg_dec !== 64'h28) begin errors++; $display("FAIL rst_new_dec: got %h expected %h", lg_dec, 64'h28); end
      checks++; if (lg_done !== 64'h80) begin errors++; $display("FAIL rst_new_done: got %h expected %h", lg_done, 64'h80); end
      checks++; if (lg_ready !== 64'h301) begin errors++; $display("FAIL rst_new_ready: got %h expected %h", lg_ready, 64'h301); end
   endtask

   task automatic test_back_to_back();
      do_req(8'd1, 4'd0, 1'b0, 5);
      checks++; if (lg_done !== 64'h10) begin errors++; $display("FAIL b2b_first_done: got %h expected %h", lg_done, 64'h10); end
      do_req(8'd2, 4'd0, 1'b0, 7);
      checks++; if (lg_ready[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", lg_ready[0]); end
      checks++; if (lg_latch !== 64'h2) begin errors++; $display("FAIL b2b_latch: got %h expected %h", lg_latch, 64'h2); end
      checks++; if (lg_dec !== 64'hC) begin errors++; $display("FAIL b2b_dec: got %h expected %h", lg_dec, 64'hC); end
      checks++; if (lg_done !== 64'h20) begin errors++; $display("FAIL b2b_done: got %h expected %h", lg_done, 64'h20); end
      checks++; if (periods !== 8'd1) begin errors++; $display("FAIL b2b_periods: got %0d expected 1", periods); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_prescale();
      test_zero_count();
      test_repeat();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
